vec_word_assembler: RTL and testbench

//   Upstream feeder for the 128-bit cosim spec stage. Accepts a stream of

---
 rtl/vec_word_assembler_pkg.sv | 18 +
 rtl/vec_word_assembler.sv | 126 ++++++++++++
 tb/tb_vec_word_assembler.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/vec_word_assembler_pkg.sv
// Shared types and defaults for the word-to-vector assembler.
// Holds the default geometry, the FSM state type and the slot-counter width helper.
package vec_asm_pkg;

  localparam int WORD_W_DEF = 32;
  localparam int NWORDS_DEF = 4;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } vec_asm_state_t;

  // Slot counter width; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vec_word_assembler.sv
// Packs NWORDS narrow words (word 0 lowest) into one vector on valid/ready handshakes.
// Optional framing check via macro VEC_ASM_FRAME_CHECK_EN (undefined: in_last ignored, frame_err 0).
module vec_word_assembler
  import vec_asm_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int NWORDS = NWORDS_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [WORD_W-1:0]        in_word_i,
  input  logic                     in_last_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [WORD_W*NWORDS-1:0] out_vec_o,
  output logic                     frame_err_o
);

  localparam int VEC_W = WORD_W * NWORDS;
  localparam int CNT_W = cnt_width(NWORDS);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NWORDS - 1);

  vec_asm_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic             valid_q, valid_d;
  logic             accept_s;
  logic             drain_s;
  logic [CNT_W-1:0] slot_s;

  // While FULL, a word can only enter together with the drain, so it lands in slot 0.
  assign in_ready_o = (state_q == FILL) ? 1'b1 : out_ready_i;
  assign accept_s   = in_valid_i && in_ready_o;
  assign drain_s    = (state_q == FULL) && out_ready_i;
  assign slot_s     = (state_q == FULL) ? {CNT_W{1'b0}} : cnt_q;

`ifdef VEC_ASM_FRAME_CHECK_EN
  logic ferr_q, ferr_d;

  // Sticky framing error: early last or missing last on the final slot.
  always_comb begin
    ferr_d = ferr_q;
    if (accept_s) begin
      if (in_last_i && (slot_s != LAST_SLOT)) begin
        ferr_d = 1'b1;
      end else if (!in_last_i && (slot_s == LAST_SLOT)) begin
        ferr_d = 1'b1;
      end else begin
        ferr_d = ferr_q;
      end
    end else begin
      ferr_d = ferr_q;
    end
  end

  // Framing error register, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ferr_q <= 1'b0;
    end else begin
      ferr_q <= ferr_d;
    end
  end

  assign frame_err_o = ferr_q;
`else
  logic unused_last_s;
  assign unused_last_s = in_last_i;
  assign frame_err_o   = 1'b0;
`endif

  // Next-state logic for FSM, slot counter, vector storage and output valid.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    valid_d = valid_q;
    if (drain_s) begin
      state_d = FILL;
      valid_d = 1'b0;
    end else begin
      state_d = state_q;
    end
    if (accept_s) begin
      vec_d[int'(slot_s)*WORD_W +: WORD_W] = in_word_i;
      if (slot_s == LAST_SLOT) begin
        cnt_d   = {CNT_W{1'b0}};
        valid_d = 1'b1;
        state_d = FULL;
      end else begin
        cnt_d = slot_s + CNT_W'(1);
      end
`ifdef VEC_ASM_FRAME_CHECK_EN
      // Early last discards the partial vector.
      if (in_last_i && (slot_s != LAST_SLOT)) begin
        cnt_d = {CNT_W{1'b0}};
      end else begin
        cnt_d = cnt_d;
      end
`endif
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      cnt_q   <= {CNT_W{1'b0}};
      vec_q   <= {VEC_W{1'b0}};
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_vec_o   = vec_q;

endmodule

// File: tb/tb_vec_word_assembler.sv
// Scoreboard bench for vec_word_assembler: stimulus pushes expected vectors, a monitor pops on handshakes.
module tb_vec_word_assembler;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_word;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_vec;
  logic         frame_err;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [127:0] exp_q[$];

  vec_word_assembler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_word_i   (in_word),
    .in_last_i   (in_last),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_vec_o   (out_vec),
    .frame_err_o (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [127:0] pack4(input logic [31:0] w0, w1, w2, w3);
    return {w3, w2, w1, w0};
  endfunction

  // Monitor: every output handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_vector", out_vec, 128'd0);
      end else begin
        check("vector", out_vec, exp_q.pop_front());
      end
    end
  end

  // Present one word and hold it until accepted (bounded wait).
  task automatic send_word(input logic [31:0] w, input logic last);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_word  = w;
    in_last  = last;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) check("accept_timeout", 128'd0, 128'd1);
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_word  = 32'hDEADBEEF;
    in_last  = 1'b0;
  endtask

  initial begin
    logic [31:0] w[8];
    logic [127:0] v;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_word   = 32'd0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_out_valid", {127'd0, out_valid}, 128'd0);
    check("reset_out_vec", out_vec, 128'd0);
    check("reset_in_ready", {127'd0, in_ready}, 128'd1);
    check("reset_frame_err", {127'd0, frame_err}, 128'd0);
    @(posedge clk);
    #1;

    // Test 1: single vector, out_ready high.
    out_ready = 1'b1;
    exp_q.push_back(128'h44444444_33333333_22222222_11111111);
    send_word(32'h11111111, 1'b0);
    send_word(32'h22222222, 1'b0);
    send_word(32'h33333333, 1'b0);
    send_word(32'h44444444, 1'b1);
    idle_in();
    check("t1_valid_high", {127'd0, out_valid}, 128'd1);
    @(posedge clk);
    #1;
    check("t1_valid_one_cycle", {127'd0, out_valid}, 128'd0);

    // Test 2: backpressure holds the vector.
    out_ready = 1'b0;
    v = pack4(32'hCAFE0000, 32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003);
    exp_q.push_back(v);
    send_word(32'hCAFE0000, 1'b0);
    send_word(32'hCAFE0001, 1'b0);
    send_word(32'hCAFE0002, 1'b0);
    in_valid = 1'b1;
    send_word(32'hCAFE0003, 1'b1);
    in_word = 32'h0BAD0BAD;
    in_last = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t2_hold_valid", {127'd0, out_valid}, 128'd1);
      check("t2_hold_vec", out_vec, v);
      check("t2_in_ready_low", {127'd0, in_ready}, 128'd0);
    end
    idle_in();
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t2_drained", {127'd0, out_valid}, 128'd0);

    // Test 3: eight words back-to-back, no bubble on in_ready.
    for (int i = 0; i < 8; i++) w[i] = 32'hA0A0A000 + 32'(i);
    exp_q.push_back(pack4(w[0], w[1], w[2], w[3]));
    exp_q.push_back(pack4(w[4], w[5], w[6], w[7]));
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_word  = w[i];
      in_last  = (i % 4 == 3) ? 1'b1 : 1'b0;
      @(negedge clk);
      check("t3_in_ready", {127'd0, in_ready}, 128'd1);
      @(posedge clk);
      #1;
    end
    idle_in();
    @(posedge clk);
    #1;
    check("t3_drained", {127'd0, out_valid}, 128'd0);

    // Test 4: reset mid-vector discards the partial vector.
    send_word(32'h55555555, 1'b0);
    send_word(32'h66666666, 1'b0);
    idle_in();
    rst_n = 1'b0;
    @(negedge clk);
    check("t4_rst_valid", {127'd0, out_valid}, 128'd0);
    check("t4_rst_cnt", {126'd0, dut.cnt_q}, 128'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.push_back(pack4(32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10));
    send_word(32'h01020304, 1'b0);
    send_word(32'h05060708, 1'b0);
    send_word(32'h090A0B0C, 1'b0);
    send_word(32'h0D0E0F10, 1'b1);
    idle_in();
    @(posedge clk);
    #1;

`ifdef VEC_ASM_FRAME_CHECK_EN
    // Test 5: early last raises sticky frame_err and drops the partial vector.
    send_word(32'h77777777, 1'b0);
    send_word(32'h88888888, 1'b1);
    idle_in();
    check("t5_frame_err_set", {127'd0, frame_err}, 128'd1);
    @(negedge clk);
    check("t5_no_vector", {127'd0, out_valid}, 128'd0);
    exp_q.push_back(pack4(32'h99999999, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC));
    send_word(32'h99999999, 1'b0);
    send_word(32'hAAAAAAAA, 1'b0);
    send_word(32'hBBBBBBBB, 1'b0);
    send_word(32'hCCCCCCCC, 1'b1);
    idle_in();
    @(posedge clk);
    #1;
    check("t5_frame_err_sticky", {127'd0, frame_err}, 128'd1);
`else
    // Test 6: in_last is ignored in the default build.
    exp_q.push_back(128'h44444444_33333333_22222222_11111111);
    send_word(32'h11111111, 1'b1);
    send_word(32'h22222222, 1'($urandom_range(0, 1)));
    send_word(32'h33333333, 1'b1);
    send_word(32'h44444444, 1'b0);
    idle_in();
    @(posedge clk);
    #1;
    check("t6_frame_err_zero", {127'd0, frame_err}, 128'd0);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
